// File: rtl/branch_ctrl_pkg.sv
// Shared types and constants for ID-stage branch hazard control.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [1:0] MTR_ALU = 2'b00;
    localparam logic [1:0] MTR_MEM = 2'b01;
    localparam logic [1:0] MTR_PC  = 2'b10;

    localparam logic [1:0] LOAD_EX_STALL  = 2'd2;
    localparam logic [1:0] LOAD_MEM_STALL = 2'd1;

    // A producer stage feeds the branch if it writes a nonzero register the branch reads.
    function automatic logic src_match(input logic       wr,
                                       input logic [4:0] rw,
                                       input logic [4:0] rs,
                                       input logic [4:0] rt,
                                       input logic       uses_rt);
        return wr && (rw != 5'd0) && ((rw == rs) || (uses_rt && (rw == rt)));
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-high reset.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en && (q != {W{1'b1}})) begin
            q <= q + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/branch_hazard_ctrl.sv
// ID-stage branch hazard sequencer: load-use stalls on branch operands,
// IF/ID flush on taken branches, and saturating performance counters.
module branch_hazard_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ext_stall,
    input  logic             kill,
    input  logic             id_branch,
    input  logic             id_uses_rt,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             branch_taken,
    input  logic [4:0]       ex_rw,
    input  logic             ex_regWr,
    input  logic [1:0]       ex_memtoreg,
    input  logic [4:0]       mem_rw,
    input  logic             mem_regWr,
    input  logic [1:0]       mem_memtoreg,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             busy,
    output logic [CNT_W-1:0] cnt_branch,
    output logic [CNT_W-1:0] cnt_taken,
    output logic [CNT_W-1:0] cnt_stall
);

    state_t     state_q, state_d;
    logic [1:0] scnt_q, scnt_d;
    logic [1:0] need;
    logic       ex_hit, mem_hit;
    logic       stall, flush, resolve;
    logic       abort;

    assign ex_hit  = src_match(ex_regWr, ex_rw, id_rs, id_rt, id_uses_rt);
    assign mem_hit = src_match(mem_regWr, mem_rw, id_rs, id_rt, id_uses_rt);
    assign abort   = kill || rst;

    // A newer EX producer shadows MEM: if EX is a non-load it forwards the live value.
    always_comb begin
        need = 2'd0;
        if (id_branch) begin
            if (ex_hit) begin
                need = (ex_memtoreg == MTR_MEM) ? LOAD_EX_STALL : 2'd0;
            end else if (mem_hit && (mem_memtoreg == MTR_MEM)) begin
                need = LOAD_MEM_STALL;
            end
        end
    end

    // The detecting IDLE cycle is itself the first stall cycle, so STALL
    // covers only the remaining need-1 cycles; scnt holds those minus one.
    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        stall   = 1'b0;
        flush   = 1'b0;
        resolve = 1'b0;
        case (state_q)
            IDLE: begin
                if (id_branch) begin
                    if (need != 2'd0) begin
                        stall = 1'b1;
                        if (need > LOAD_MEM_STALL) begin
                            state_d = STALL;
                            scnt_d  = need - 2'd2;
                        end
                    end else begin
                        resolve = 1'b1;
                        if (branch_taken) begin
                            state_d = FLUSH;
                        end
                    end
                end
            end
            STALL: begin
                stall = 1'b1;
                if (scnt_q == 2'd0) begin
                    state_d = IDLE;
                end else begin
                    scnt_d = scnt_q - 2'd1;
                end
            end
            FLUSH: begin
                flush   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                scnt_d  = 2'd0;
            end
        endcase
        if (ext_stall) begin
            state_d = state_q;
            scnt_d  = scnt_q;
        end
        if (abort) begin
            state_d = IDLE;
            scnt_d  = 2'd0;
            stall   = 1'b0;
            flush   = 1'b0;
            resolve = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            scnt_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            scnt_q  <= scnt_d;
        end
    end

    assign pc_stall    = stall;
    assign ifid_stall  = stall;
    assign idex_bubble = stall;
    assign ifid_flush  = flush;
    assign busy        = (state_q != IDLE) && !abort;

    sat_counter #(.W(CNT_W)) u_cnt_branch (
        .clk (clk),
        .rst (rst),
        .en  (resolve && !ext_stall),
        .q   (cnt_branch)
    );

    sat_counter #(.W(CNT_W)) u_cnt_taken (
        .clk (clk),
        .rst (rst),
        .en  (resolve && branch_taken && !ext_stall),
        .q   (cnt_taken)
    );

    sat_counter #(.W(CNT_W)) u_cnt_stall (
        .clk (clk),
        .rst (rst),
        .en  (stall && !ext_stall),
        .q   (cnt_stall)
    );

endmodule
